// File: rtl/ex_core_fetch.sv
// rtl/ex_core_fetch.sv - instruction fetch front end with credit-limited requests and a decode queue
module ex_core_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IQ_DEPTH = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic        IMemReqValid,
    output logic [31:0] IMemReqAddr,
    input  logic        IMemReqReady,
    input  logic        IMemRspValid,
    input  logic [31:0] IMemRspData,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectPc,
    output logic        InstValidQ101H,
    output logic [31:0] InstQ101H,
    output logic [31:0] InstPcQ101H,
    input  logic        InstReady
);

    localparam int         PW    = (IQ_DEPTH == 4) ? 2 : 1;
    localparam logic [3:0] DEPTH = 4'(IQ_DEPTH);

    logic [31:0]   fetch_pc;
    logic [2:0]    outstanding;
    logic [2:0]    drop_cnt;
    logic [2:0]    q_cnt;
    logic [31:0]   pcf_mem [IQ_DEPTH];
    logic [PW-1:0] pcf_wr;
    logic [PW-1:0] pcf_rd;
    logic [31:0]   q_inst [IQ_DEPTH];
    logic [31:0]   q_pc [IQ_DEPTH];
    logic [PW-1:0] q_wr;
    logic [PW-1:0] q_rd;

    logic       credit_ok;
    logic       req_acc;
    logic       rsp_known;
    logic       rsp_drop;
    logic       rsp_take;
    logic       deq;
    logic [3:0] inflight;
    logic [2:0] out_next;
    logic       unused_pc_bits;

    assign unused_pc_bits = ^RedirectPc[1:0];

    // Credits cover both in-flight requests and queued words, so a response always has a slot.
    assign inflight  = {1'b0, outstanding} + {1'b0, q_cnt};
    assign credit_ok = inflight < DEPTH;

    assign IMemReqValid = Rst && credit_ok && !RedirectValid && (drop_cnt == 3'd0);
    assign IMemReqAddr  = fetch_pc;
    assign req_acc      = IMemReqValid && IMemReqReady;

    // A response with nothing outstanding is a protocol error and is ignored entirely.
    assign rsp_known = IMemRspValid && (outstanding != 3'd0);
    assign rsp_drop  = rsp_known && (drop_cnt != 3'd0);
    assign rsp_take  = rsp_known && (drop_cnt == 3'd0) && !RedirectValid;
    assign out_next  = outstanding + {2'b00, req_acc} - {2'b00, rsp_known};

    assign InstValidQ101H = (q_cnt != 3'd0);
    assign InstQ101H      = InstValidQ101H ? q_inst[q_rd] : 32'h0;
    assign InstPcQ101H    = InstValidQ101H ? q_pc[q_rd]   : 32'h0;
    assign deq            = InstValidQ101H && InstReady && !RedirectValid;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= 3'd0;
            drop_cnt    <= 3'd0;
            q_cnt       <= 3'd0;
            q_wr        <= '0;
            q_rd        <= '0;
            pcf_wr      <= '0;
            pcf_rd      <= '0;
        end else if (RedirectValid) begin
            // Everything still in flight belongs to the old path and must be swallowed.
            fetch_pc    <= {RedirectPc[31:2], 2'b00};
            outstanding <= out_next;
            drop_cnt    <= out_next;
            q_cnt       <= 3'd0;
            q_wr        <= '0;
            q_rd        <= '0;
            pcf_wr      <= '0;
            pcf_rd      <= '0;
        end else begin
            outstanding <= out_next;
            if (req_acc) begin
                fetch_pc <= fetch_pc + 32'd4;
                pcf_wr   <= pcf_wr + PW'(1);
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - 3'd1;
            end
            if (rsp_take) begin
                pcf_rd <= pcf_rd + PW'(1);
                q_wr   <= q_wr + PW'(1);
            end
            if (deq) begin
                q_rd <= q_rd + PW'(1);
            end
            q_cnt <= q_cnt + {2'b00, rsp_take} - {2'b00, deq};
        end
    end

    always_ff @(posedge Clk) begin
        if (req_acc) begin
            pcf_mem[pcf_wr] <= fetch_pc;
        end
        if (rsp_take) begin
            q_inst[q_wr] <= IMemRspData;
            q_pc[q_wr]   <= pcf_mem[pcf_rd];
        end
    end

    a_no_stray_rsp: assert property (@(posedge Clk) disable iff (!Rst)
        !(IMemRspValid && (outstanding == 3'd0)));

    a_outstanding_bound: assert property (@(posedge Clk) disable iff (!Rst)
        ({1'b0, outstanding} <= DEPTH));

endmodule

// File: tb/tb_ex_core_fetch.sv
// tb/tb_ex_core_fetch.sv - directed self-checking bench for ex_core_fetch
module tb_ex_core_fetch;

    logic        Clk;
    logic        Rst;

    logic        a_req_valid;
    logic [31:0] a_req_addr;
    logic        a_req_ready;
    logic        a_rsp_valid;
    logic [31:0] a_rsp_data;
    logic        a_redirect;
    logic [31:0] a_redirect_pc;
    logic        a_inst_valid;
    logic [31:0] a_inst;
    logic [31:0] a_inst_pc;
    logic        a_inst_ready;

    logic        b_req_valid;
    logic [31:0] b_req_addr;
    logic        b_req_ready;
    logic        b_rsp_valid;
    logic [31:0] b_rsp_data;
    logic        b_redirect;
    logic [31:0] b_redirect_pc;
    logic        b_inst_valid;
    logic [31:0] b_inst;
    logic [31:0] b_inst_pc;
    logic        b_inst_ready;

    int          checks;
    int          errors;
    int          cyc;
    int          a_lat;
    int          bp_reqs;
    int          pend_due[$];
    logic [31:0] pend_addr[$];

    ex_core_fetch #(.RESET_PC(32'h0000_0000), .IQ_DEPTH(2)) dut_a (
        .Clk            (Clk),
        .Rst            (Rst),
        .IMemReqValid   (a_req_valid),
        .IMemReqAddr    (a_req_addr),
        .IMemReqReady   (a_req_ready),
        .IMemRspValid   (a_rsp_valid),
        .IMemRspData    (a_rsp_data),
        .RedirectValid  (a_redirect),
        .RedirectPc     (a_redirect_pc),
        .InstValidQ101H (a_inst_valid),
        .InstQ101H      (a_inst),
        .InstPcQ101H    (a_inst_pc),
        .InstReady      (a_inst_ready)
    );

    ex_core_fetch #(.RESET_PC(32'hFFFF_FFF8), .IQ_DEPTH(4)) dut_b (
        .Clk            (Clk),
        .Rst            (Rst),
        .IMemReqValid   (b_req_valid),
        .IMemReqAddr    (b_req_addr),
        .IMemReqReady   (b_req_ready),
        .IMemRspValid   (b_rsp_valid),
        .IMemRspData    (b_rsp_data),
        .RedirectValid  (b_redirect),
        .RedirectPc     (b_redirect_pc),
        .InstValidQ101H (b_inst_valid),
        .InstQ101H      (b_inst),
        .InstPcQ101H    (b_inst_pc),
        .InstReady      (b_inst_ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, then drive memory responses after it.
    task automatic tick();
        logic        a_acc;
        logic        b_acc;
        logic [31:0] a_addr_s;
        logic [31:0] b_addr_s;
        @(negedge Clk);
        a_acc    = a_req_valid && a_req_ready;
        a_addr_s = a_req_addr;
        b_acc    = b_req_valid && b_req_ready;
        b_addr_s = b_req_addr;
        @(posedge Clk);
        #1;
        cyc++;
        if (a_acc) begin
            pend_due.push_back(cyc - 1 + a_lat);
            pend_addr.push_back(a_addr_s);
        end
        a_rsp_valid = 1'b0;
        a_rsp_data  = 32'h0;
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
            a_rsp_valid = 1'b1;
            a_rsp_data  = mem_word(pend_addr[0]);
            void'(pend_due.pop_front());
            void'(pend_addr.pop_front());
        end
        b_rsp_valid = b_acc;
        b_rsp_data  = mem_word(b_addr_s);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        a_lat  = 1;
        Rst           = 1'b1;
        a_req_ready   = 1'b0;
        a_rsp_valid   = 1'b0;
        a_rsp_data    = 32'h0;
        a_redirect    = 1'b0;
        a_redirect_pc = 32'h0;
        a_inst_ready  = 1'b1;
        b_req_ready   = 1'b1;
        b_rsp_valid   = 1'b0;
        b_rsp_data    = 32'h0;
        b_redirect    = 1'b0;
        b_redirect_pc = 32'h0;
        b_inst_ready  = 1'b1;
        #1 Rst = 1'b0;
        #1;
        chk("rst_req_valid", a_req_valid, 1'b0);
        chk("rst_inst_valid", a_inst_valid, 1'b0);
        chk("rst_inst", a_inst, 32'h0);
        chk("rst_inst_pc", a_inst_pc, 32'h0);
        chk("rst_req_addr", a_req_addr, 32'h0);
        chk("rst_b_req_valid", b_req_valid, 1'b0);
        chk("rst_b_req_addr", b_req_addr, 32'hFFFF_FFF8);
        tick();
        tick();

        // c0: first cycle out of reset; A stalls on ready=0, B streams across the wrap
        Rst = 1'b1;
        #1;
        chk("c0_a_req_valid", a_req_valid, 1'b1);
        chk("c0_a_req_addr", a_req_addr, 32'h0);
        chk("c0_b_req_addr", b_req_addr, 32'hFFFF_FFF8);
        tick(); #1;
        chk("c1_a_stall_addr", a_req_addr, 32'h0);
        chk("c1_b_req_addr", b_req_addr, 32'hFFFF_FFFC);
        chk("c1_b_inst_valid", b_inst_valid, 1'b0);
        tick(); #1;
        chk("c2_a_stall_addr", a_req_addr, 32'h0);
        chk("c2_a_stall_valid", a_req_valid, 1'b1);
        chk("c2_b_wrap_addr", b_req_addr, 32'h0000_0000);
        chk("c2_b_head_pc", b_inst_pc, 32'hFFFF_FFF8);
        chk("c2_b_head_data", b_inst, mem_word(32'hFFFF_FFF8));
        a_redirect    = 1'b1;
        a_redirect_pc = 32'h0000_0203;
        #1;
        chk("c2_a_redirect_blocks_req", a_req_valid, 1'b0);
        tick();
        a_redirect  = 1'b0;
        a_req_ready = 1'b1;
        #1;
        chk("c3_a_redirect_addr", a_req_addr, 32'h0000_0200);
        chk("c3_a_req_valid", a_req_valid, 1'b1);
        chk("c3_b_head_pc", b_inst_pc, 32'hFFFF_FFFC);
        tick(); #1;
        chk("c4_a_req_addr", a_req_addr, 32'h0000_0204);
        chk("c4_a_inst_valid", a_inst_valid, 1'b0);
        chk("c4_b_head_pc", b_inst_pc, 32'h0);
        chk("c4_b_head_valid", b_inst_valid, 1'b1);
        tick(); #1;
        chk("c5_a_credit_full", a_req_valid, 1'b0);
        chk("c5_a_head_pc", a_inst_pc, 32'h0000_0200);
        chk("c5_a_head_data", a_inst, mem_word(32'h0000_0200));
        chk("c5_b_head_pc", b_inst_pc, 32'h4);
        tick(); #1;
        chk("c6_a_head_pc", a_inst_pc, 32'h0000_0204);
        chk("c6_a_req_valid", a_req_valid, 1'b1);
        chk("c6_a_req_addr", a_req_addr, 32'h0000_0208);
        chk("c6_b_head_pc", b_inst_pc, 32'h8);
        tick(); #1;
        chk("c7_a_inst_valid", a_inst_valid, 1'b0);
        chk("c7_a_req_addr", a_req_addr, 32'h0000_020C);
        chk("c7_b_head_pc", b_inst_pc, 32'hC);
        chk("c7_b_head_data", b_inst, mem_word(32'hC));
        chk("c7_b_head_valid", b_inst_valid, 1'b1);

        // Decode back-pressure for ten cycles
        a_inst_ready = 1'b0;
        bp_reqs = 0;
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            if (a_req_valid) bp_reqs++;
        end
        chk("bp_no_requests", bp_reqs, 0);
        chk("bp_head_pc", a_inst_pc, 32'h0000_0208);
        chk("bp_head_data", a_inst, mem_word(32'h0000_0208));
        a_inst_ready = 1'b1;
        tick(); #1;
        chk("bp_resume_head_pc", a_inst_pc, 32'h0000_020C);
        chk("bp_resume_req_valid", a_req_valid, 1'b1);
        chk("bp_resume_req_addr", a_req_addr, 32'h0000_0210);
        tick(); #1;
        chk("bp_fill_bubble", a_inst_valid, 1'b0);
        tick(); #1;
        chk("bp_resume_next_pc", a_inst_pc, 32'h0000_0210);
        a_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #1;
        chk("drain_inst_valid", a_inst_valid, 1'b0);
        chk("drain_req_addr", a_req_addr, 32'h0000_0218);

        // Two outstanding with latency 2, then redirect while both are in flight
        a_lat       = 2;
        a_req_ready = 1'b1;
        tick(); #1;
        chk("d1_req_addr", a_req_addr, 32'h0000_021C);
        chk("d1_req_valid", a_req_valid, 1'b1);
        tick();
        a_redirect    = 1'b1;
        a_redirect_pc = 32'h0000_0103;
        #1;
        chk("d2_req_valid", a_req_valid, 1'b0);
        tick();
        a_redirect = 1'b0;
        #1;
        chk("d3_dropping_req_valid", a_req_valid, 1'b0);
        chk("d3_inst_valid", a_inst_valid, 1'b0);
        tick(); #1;
        chk("d4_req_valid", a_req_valid, 1'b1);
        chk("d4_req_addr", a_req_addr, 32'h0000_0100);
        chk("d4_inst_valid", a_inst_valid, 1'b0);
        tick(); #1;
        chk("d5_req_addr", a_req_addr, 32'h0000_0104);
        chk("d5_inst_valid", a_inst_valid, 1'b0);
        tick(); #1;
        chk("d6_inst_valid", a_inst_valid, 1'b0);
        tick(); #1;
        chk("d7_inst_valid", a_inst_valid, 1'b1);
        chk("d7_head_pc", a_inst_pc, 32'h0000_0100);
        chk("d7_head_data", a_inst, mem_word(32'h0000_0100));

        // Asynchronous reset between edges, mid-stream
        tick();
        #2;
        Rst = 1'b0;
        pend_due.delete();
        pend_addr.delete();
        a_rsp_valid = 1'b0;
        b_rsp_valid = 1'b0;
        #1;
        chk("ar_req_valid", a_req_valid, 1'b0);
        chk("ar_inst_valid", a_inst_valid, 1'b0);
        chk("ar_inst", a_inst, 32'h0);
        chk("ar_inst_pc", a_inst_pc, 32'h0);
        chk("ar_req_addr", a_req_addr, 32'h0);
        chk("ar_b_req_valid", b_req_valid, 1'b0);
        tick();
        Rst   = 1'b1;
        a_lat = 1;
        #1;
        chk("ar_restart_valid", a_req_valid, 1'b1);
        chk("ar_restart_addr", a_req_addr, 32'h0);
        chk("ar_b_restart_addr", b_req_addr, 32'hFFFF_FFF8);
        tick(); #1;
        chk("ar_second_addr", a_req_addr, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_core_fetch.md
EX_CORE_FETCH -- requirements
Module: ex_core_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter IQ_DEPTH, default 2, instruction-queue entries; legal values 2 and 4 only.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-low.
REQ-005 IMemReqValid  output  1  fetch request valid.
REQ-006 IMemReqAddr  output  32  fetch byte address, bits [1:0] always 0.
REQ-007 IMemReqReady  input  1  memory accepts request this cycle.
REQ-008 IMemRspValid  input  1  in-order response valid; memory never stalls a response.
REQ-009 IMemRspData  input  32  fetched instruction word.
REQ-010 RedirectValid  input  1  branch/jump taken; single-cycle pulse from execute.
REQ-011 RedirectPc  input  32  redirect target; bits [1:0] ignored and treated as 0.
REQ-012 InstValidQ101H  output  1  queue head valid toward decode.
REQ-013 InstQ101H  output  32  queue head instruction.
REQ-014 InstPcQ101H  output  32  PC of queue head instruction.
REQ-015 InstReady  input  1  decode consumes head when InstValidQ101H and InstReady are both high.

Function
REQ-016 Fetch PC register: advances by 4 on each accepted request (IMemReqValid and IMemReqReady); 32-bit wrap, 32'hFFFF_FFFC+4 -> 0.
REQ-017 Credit rule: IMemReqValid = 1 only when (outstanding + queue occupancy) < IQ_DEPTH, no redirect this cycle, and drop count = 0.
REQ-018 IMemReqAddr = fetch PC whenever IMemReqValid = 1; held stable while IMemReqValid=1 and IMemReqReady=0.
REQ-019 Outstanding counter: +1 on accepted request, -1 on IMemRspValid; simultaneous events leave it unchanged; never exceeds IQ_DEPTH.
REQ-020 An internal PC FIFO (depth IQ_DEPTH) records each accepted request address; pops on each response; response data is enqueued with the popped PC.
REQ-021 Queue: FIFO of {instruction, PC}, head drives InstQ101H/InstPcQ101H combinationally; enqueue and dequeue in the same cycle keep occupancy unchanged.
REQ-022 Fetch-to-decode latency: response in cycle N -> InstValidQ101H = 1 in cycle N+1 when the queue was empty.
REQ-023 Redirect (RedirectValid=1 in cycle N): fetch PC <= {RedirectPc[31:2],2'b00}; queue and PC FIFO flushed; drop count <= outstanding after cycle N updates; InstValidQ101H = 0 in cycle N+1.
REQ-024 Redirect has priority over InstReady, request acceptance and response enqueue in the same cycle; a response in cycle N is discarded.
REQ-025 Responses arriving while drop count > 0 are discarded and decrement drop count; first request to the redirect target issues in the first cycle with drop count = 0, earliest N+1.
REQ-026 Back-to-back redirects: the later one wins; drop count recomputed from current outstanding.
REQ-027 InstValidQ101H = 0 while queue empty; InstQ101H and InstPcQ101H are don't-care when invalid but drive 0 after reset.
REQ-028 IMemRspValid with outstanding = 0 and drop count = 0 is a protocol error; response ignored; simulation assertion fires.

Reset
REQ-029 Rst low: immediately (asynchronously) IMemReqValid=0, InstValidQ101H=0, InstQ101H=0, InstPcQ101H=0, queue empty, outstanding=0, drop count=0, fetch PC=RESET_PC.
REQ-030 Reset mid-operation discards all in-flight requests and queued instructions; responses for pre-reset requests must not arrive after release (memory is reset together).
REQ-031 First request (IMemReqAddr=RESET_PC) is asserted in the first cycle after Rst deasserts.

Verification
REQ-032 Streaming: ready=1, 1-cycle response latency, InstReady=1 -> PCs 0,4,8,12 appear on consecutive cycles with matching data, no bubbles after fill.
REQ-033 Back-pressure: InstReady=0 for 10 cycles, IQ_DEPTH=2 -> exactly 2 requests issued then IMemReqValid=0; on InstReady=1, order 0,4 then 8 resumes.
REQ-034 Redirect with 2 outstanding: RedirectValid, RedirectPc=32'h0000_0103 -> both old responses dropped, next request address 32'h0000_0100, decode sees no old-path instruction.
REQ-035 Wrap: RESET_PC=32'hFFFF_FFF8 -> request addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-036 Memory stall: IMemReqReady=0 for 3 cycles -> IMemReqAddr held constant, PC not advanced; redirect during stall replaces the address next cycle.
REQ-037 Async reset asserted mid-stream between clock edges -> all outputs 0 before next edge; restart fetches RESET_PC.
